// File: rtl/square_sweep_chan.sv
// square_sweep_chan: APU pulse channel (duty, envelope, length); define SQ_SWEEP_EN to compile in the frequency sweep unit
module square_sweep_chan #(
  parameter int FREQ_W = 11,
  parameter int LEN_W = 6
) (
  input  logic              dyfa_1mhz,
  input  logic              apu_reset,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              len_tick,
  input  logic              sweep_tick,
  input  logic              env_tick,
  output logic [3:0]        ch_out,
  output logic              ch_active,
  output logic              dac_en,
  output logic [FREQ_W-1:0] ch_freq
);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  logic [1:0] duty_q, duty_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic len_en_q, len_en_d;
  logic [7:0] nr12_q, nr12_d;
  logic [FREQ_W-1:0] freq_q, freq_d, freq_new, period_q, period_d;
  logic [2:0] step_q, step_d, env_tmr_q, env_tmr_d;
  logic [3:0] vol_q, vol_d;
  logic active_q, active_d;
  logic wr_nr11, wr_nr12, wr_nr13, wr_nr14, trig;
  logic len_step, len_expire, env_step, env_hit, trig_ovf, sweep_kill, duty_bit;
  logic [7:0] pattern;
  assign wr_nr11 = wr_en && wr_addr == 3'd1;
  assign wr_nr12 = wr_en && wr_addr == 3'd2;
  assign wr_nr13 = wr_en && wr_addr == 3'd3;
  assign wr_nr14 = wr_en && wr_addr == 3'd4;
  assign trig = wr_nr14 && wr_data[7];
  // frequency as it stands after this cycle's register write, before any sweep write-back
  assign freq_new = wr_nr13 ? {freq_q[FREQ_W-1:8], wr_data}
                  : wr_nr14 ? {wr_data[FREQ_W-9:0], freq_q[7:0]} : freq_q;
  always_comb begin
    len_step   = !wr_nr11 && !trig && len_tick && len_en_q && len_q != LEN_MAX;
    len_expire = len_step && len_q == LEN_MAX - 1'b1;
    env_step   = !trig && env_tick && nr12_q[2:0] != 3'd0;
    env_hit    = env_step && env_tmr_q <= 3'd1;
    duty_d     = wr_nr11 ? wr_data[7:6] : duty_q;
    len_d      = wr_nr11 ? wr_data[LEN_W-1:0] : (trig && len_q == LEN_MAX) ? '0 : len_step ? len_q + 1'b1 : len_q;
    len_en_d   = wr_nr14 ? wr_data[6] : len_en_q;
    nr12_d     = wr_nr12 ? wr_data : nr12_q;
    period_d   = trig ? freq_new : &period_q ? freq_q : period_q + 1'b1;
    step_d     = &period_q ? step_q + 1'b1 : step_q;
    env_tmr_d  = (trig || env_hit) ? nr12_q[2:0] : env_step ? env_tmr_q - 1'b1 : env_tmr_q;
    vol_d      = trig ? nr12_q[7:4] : !env_hit ? vol_q
               : nr12_q[3] ? (&vol_q ? vol_q : vol_q + 1'b1) : (vol_q == 4'd0 ? vol_q : vol_q - 1'b1);
    active_d   = trig ? (dac_en && !trig_ovf)
               : active_q && !(wr_nr12 && wr_data[7:3] == 5'd0) && !len_expire && !sweep_kill;
  end
`ifdef SQ_SWEEP_EN
  logic [6:0] nr10_q, nr10_d;
  logic [FREQ_W-1:0] shadow_q, shadow_d;
  logic [3:0] swp_tmr_q, swp_tmr_d, swp_reload;
  logic swp_on_q, swp_on_d, swp_step, swp_hit, swp_do, swp_wb;
  logic [FREQ_W:0] trig_calc, swp_calc, swp_recheck;
  function automatic logic [FREQ_W:0] sweep_calc(input logic [FREQ_W-1:0] f, input logic sub, input logic [2:0] sh);
    sweep_calc = sub ? {1'b0, f} - {1'b0, f >> sh} : {1'b0, f} + {1'b0, f >> sh};
  endfunction
  always_comb begin
    swp_reload  = nr10_q[6:4] == 3'd0 ? 4'd8 : {1'b0, nr10_q[6:4]};
    trig_calc   = sweep_calc(freq_new, nr10_q[3], nr10_q[2:0]);
    swp_calc    = sweep_calc(shadow_q, nr10_q[3], nr10_q[2:0]);
    swp_recheck = sweep_calc(swp_calc[FREQ_W-1:0], nr10_q[3], nr10_q[2:0]);
    swp_step    = !trig && sweep_tick;
    swp_hit     = swp_step && swp_tmr_q <= 4'd1;
    swp_do      = swp_hit && swp_on_q && nr10_q[6:4] != 3'd0;
    swp_wb      = swp_do && !swp_calc[FREQ_W] && nr10_q[2:0] != 3'd0;
    trig_ovf    = nr10_q[2:0] != 3'd0 && trig_calc[FREQ_W];
    sweep_kill  = (swp_do && swp_calc[FREQ_W]) || (swp_wb && swp_recheck[FREQ_W]);
    nr10_d      = (wr_en && wr_addr == 3'd0) ? wr_data[6:0] : nr10_q;
    shadow_d    = trig ? freq_new : swp_wb ? swp_calc[FREQ_W-1:0] : shadow_q;
    swp_tmr_d   = (trig || swp_hit) ? swp_reload : swp_step ? swp_tmr_q - 1'b1 : swp_tmr_q;
    swp_on_d    = trig ? (nr10_q[6:4] != 3'd0 || nr10_q[2:0] != 3'd0) : swp_on_q;
    freq_d      = (swp_wb && !wr_nr13 && !wr_nr14) ? swp_calc[FREQ_W-1:0] : freq_new;
  end
  always_ff @(posedge dyfa_1mhz) begin
    if (apu_reset) begin
      nr10_q    <= '0;
      shadow_q  <= '0;
      swp_tmr_q <= '0;
      swp_on_q  <= 1'b0;
    end else begin
      nr10_q    <= nr10_d;
      shadow_q  <= shadow_d;
      swp_tmr_q <= swp_tmr_d;
      swp_on_q  <= swp_on_d;
    end
  end
`else
  logic sweep_unused;
  assign sweep_unused = sweep_tick;
  assign trig_ovf = 1'b0;
  assign sweep_kill = 1'b0;
  assign freq_d = freq_new;
`endif
  always_ff @(posedge dyfa_1mhz) begin
    if (apu_reset) begin
      duty_q    <= '0;
      len_q     <= '0;
      len_en_q  <= 1'b0;
      nr12_q    <= '0;
      freq_q    <= '0;
      period_q  <= '0;
      step_q    <= '0;
      env_tmr_q <= '0;
      vol_q     <= '0;
      active_q  <= 1'b0;
    end else begin
      duty_q    <= duty_d;
      len_q     <= len_d;
      len_en_q  <= len_en_d;
      nr12_q    <= nr12_d;
      freq_q    <= freq_d;
      period_q  <= period_d;
      step_q    <= step_d;
      env_tmr_q <= env_tmr_d;
      vol_q     <= vol_d;
      active_q  <= active_d;
    end
  end
  assign pattern = duty_q == 2'd0 ? 8'b00000001 : duty_q == 2'd1 ? 8'b10000001
                 : duty_q == 2'd2 ? 8'b10000111 : 8'b01111110;
  assign duty_bit = pattern[3'd7 - step_q];
  assign ch_out = (active_q && duty_bit) ? vol_q : 4'd0;
  assign ch_active = active_q;
  assign dac_en = nr12_q[7:3] != 5'd0;
  assign ch_freq = freq_q;
endmodule
